// File: rtl/uart_host_if_if.sv
// CPU-side register bus between the memory-mapped I/O decode and uart_host_if.
// The master drives address, data and strobes; the slave returns read data and irq.
interface uart_host_if_if;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       irq;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, irq
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, irq
  );
endinterface

// File: rtl/uart_host_if.sv
// CPU-facing end of the UART core byte handshake: 4-register byte bus, TX/RX FIFOs,
// a TX launcher FSM feeding the core, and an RX capture FSM acknowledging the core.
module uart_host_if #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_host_if_if.slave  bus,
  output logic [7:0]     data_tx,
  output logic           have_data_tx,
  input  logic           transmitting,
  input  logic [7:0]     data_rx,
  input  logic           have_data_rx,
  output logic           data_rx_ack
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_START, TX_WAIT_END} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_ACK} rx_state_t;

  tx_state_t        r_tx_state, w_tx_state_nxt;
  rx_state_t        r_rx_state, w_rx_state_nxt;

  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_tx_rd_ptr, r_tx_wr_ptr;
  logic [CNT_W-1:0] r_tx_count;
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rx_rd_ptr, r_rx_wr_ptr;
  logic [CNT_W-1:0] r_rx_count;

  logic             r_rx_overrun, r_tx_overflow;
  logic [7:0]       r_bus_rdata;
  logic [7:0]       r_data_tx;
  logic             r_have_data_tx;
  logic             r_data_rx_ack;

  logic             w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
  logic             w_tx_launch, w_tx_push_req, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic             w_rx_capture, w_rx_push, w_rx_pop, w_rx_ovr_set;
  logic             w_clr_wr;
  logic [7:0]       w_rdata_nxt;

  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == DEPTH_C);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == DEPTH_C);
  assign w_tx_busy  = !w_tx_empty || (r_tx_state != TX_IDLE);

  // TX launcher: one start pulse per byte, then follow the core's busy envelope
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_launch    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty && !transmitting) begin
          w_tx_launch    = 1'b1;
          w_tx_state_nxt = TX_WAIT_START;
        end
      end
      TX_WAIT_START: if (transmitting)  w_tx_state_nxt = TX_WAIT_END;
      TX_WAIT_END:   if (!transmitting) w_tx_state_nxt = TX_IDLE;
      default:       w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // RX capture: take one byte per have_data_rx level, re-arm only once it drops
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_capture   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (have_data_rx) begin
          w_rx_capture   = 1'b1;
          w_rx_state_nxt = RX_ACK;
        end
      end
      RX_ACK:  if (!have_data_rx) w_rx_state_nxt = RX_IDLE;
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_tx_push_req = bus.bus_we && (bus.bus_addr == A_DATA);
  assign w_tx_pop      = w_tx_launch;
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf_set  = w_tx_push_req && !w_tx_push;

  assign w_rx_pop      = bus.bus_re && (bus.bus_addr == A_DATA) && !w_rx_empty;
  assign w_rx_push     = w_rx_capture && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr_set  = w_rx_capture && !w_rx_push;

  assign w_clr_wr      = bus.bus_we && (bus.bus_addr == A_CLEAR);

  always_comb begin
    w_rdata_nxt = 8'h00;
    case (bus.bus_addr)
      A_DATA:   w_rdata_nxt = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
      A_STATUS: w_rdata_nxt = {2'b00, r_tx_overflow, r_rx_overrun, w_tx_busy,
                               w_tx_empty, w_tx_full, !w_rx_empty};
      A_CLEAR:  w_rdata_nxt = 8'h00;
      A_COUNT:  w_rdata_nxt = {r_tx_count, r_rx_count};
      default:  w_rdata_nxt = 8'h00;
    endcase
  end

  // FIFO storage carries no reset; pointers and counts define validity
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= bus.bus_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= data_rx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state     <= TX_IDLE;
      r_rx_state     <= RX_IDLE;
      r_tx_rd_ptr    <= '0;
      r_tx_wr_ptr    <= '0;
      r_tx_count     <= '0;
      r_rx_rd_ptr    <= '0;
      r_rx_wr_ptr    <= '0;
      r_rx_count     <= '0;
      r_rx_overrun   <= 1'b0;
      r_tx_overflow  <= 1'b0;
      r_bus_rdata    <= 8'h00;
      r_data_tx      <= 8'h00;
      r_have_data_tx <= 1'b0;
      r_data_rx_ack  <= 1'b0;
    end else begin
      r_tx_state     <= w_tx_state_nxt;
      r_rx_state     <= w_rx_state_nxt;
      r_have_data_tx <= w_tx_launch;
      r_data_rx_ack  <= w_rx_capture;

      if (w_tx_launch) r_data_tx <= r_tx_mem[r_tx_rd_ptr];
      if (w_tx_push)   r_tx_wr_ptr <= r_tx_wr_ptr + PTR_W'(1);
      if (w_tx_pop)    r_tx_rd_ptr <= r_tx_rd_ptr + PTR_W'(1);
      r_tx_count <= r_tx_count + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);

      if (w_rx_push)   r_rx_wr_ptr <= r_rx_wr_ptr + PTR_W'(1);
      if (w_rx_pop)    r_rx_rd_ptr <= r_rx_rd_ptr + PTR_W'(1);
      r_rx_count <= r_rx_count + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);

      // Sticky flags: a set in the same cycle as a clear wins
      if (w_rx_ovr_set)                          r_rx_overrun  <= 1'b1;
      else if (w_clr_wr && bus.bus_wdata[0])     r_rx_overrun  <= 1'b0;
      if (w_tx_ovf_set)                          r_tx_overflow <= 1'b1;
      else if (w_clr_wr && bus.bus_wdata[1])     r_tx_overflow <= 1'b0;

      if (bus.bus_re) r_bus_rdata <= w_rdata_nxt;
    end
  end

  assign bus.bus_rdata = r_bus_rdata;
  assign bus.irq       = !w_rx_empty || r_rx_overrun;
  assign data_tx       = r_data_tx;
  assign have_data_tx  = r_have_data_tx;
  assign data_rx_ack   = r_data_rx_ack;

endmodule

// File: tb/tb_uart_host_if.sv
// Directed-plus-random bench for uart_host_if: a timed core model drives the handshake,
// and queue-based models of both FIFOs and the sticky flags supply every expected value.
module tb_uart_host_if;
  localparam int DEPTH   = 4;
  localparam int CORE_LEN = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_tx;
  logic       have_data_tx;
  logic       transmitting;
  logic [7:0] data_rx;
  logic       have_data_rx;
  logic       data_rx_ack;

  uart_host_if_if bus ();

  uart_host_if #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .data_tx      (data_tx),
    .have_data_tx (have_data_tx),
    .transmitting (transmitting),
    .data_rx      (data_rx),
    .have_data_rx (have_data_rx),
    .data_rx_ack  (data_rx_ack)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         bad_pulses = 0;
  int         acks = 0;
  int         nsends = 0;
  logic       tr_prev = 1'b0;
  logic [7:0] tx_seen [$];
  logic [7:0] tx_exp  [$];
  logic [7:0] rx_q    [$];
  bit         m_ovf = 1'b0;
  bit         m_ovr = 1'b0;

  // Observe start pulses and acks mid-cycle; a pulse while the core was already busy is a retrigger
  always @(negedge clk) begin
    if (have_data_tx === 1'b1) begin
      tx_seen.push_back(data_tx);
      if (tr_prev) bad_pulses++;
    end
    if (data_rx_ack === 1'b1) acks++;
    tr_prev = transmitting;
  end

  // Core model: busy for CORE_LEN cycles after each start pulse
  initial begin
    transmitting = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (have_data_tx === 1'b1) begin
        transmitting = 1'b1;
        repeat (CORE_LEN) @(posedge clk);
        #1;
        transmitting = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tx_pending();
    return tx_exp.size() - tx_seen.size();
  endfunction

  function automatic logic [7:0] exp_status(input bit busy);
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (rx_q.size() != 0);
    s[1] = (tx_pending() == DEPTH);
    s[2] = (tx_pending() == 0);
    s[3] = busy;
    s[4] = m_ovr;
    s[5] = m_ovf;
    return s;
  endfunction

  function automatic logic [7:0] exp_count();
    return {4'(tx_pending()), 4'(rx_q.size())};
  endfunction

  function automatic logic exp_irq();
    return (rx_q.size() != 0) || m_ovr;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    bus.bus_we    = 1'b1;
    tick;
    bus.bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.bus_addr = a;
    bus.bus_re   = 1'b1;
    tick;
    bus.bus_re   = 1'b0;
    d            = bus.bus_rdata;
  endtask

  task automatic tx_write(input logic [7:0] b);
    if (tx_pending() < DEPTH) tx_exp.push_back(b);
    else                      m_ovf = 1'b1;
    wr(2'd0, b);
  endtask

  task automatic wait_pulses(input int n);
    int b = 0;
    while (tx_seen.size() < n && b < 200) begin tick; b++; end
    check("tx_pulse_wait", 32'(tx_seen.size() >= n), 32'd1);
  endtask

  task automatic wait_tx_idle;
    int b = 0;
    while ((tx_pending() > 0 || transmitting) && b < 600) begin tick; b++; end
    check("tx_drain_wait", 32'(b < 600), 32'd1);
    repeat (3) tick;
  endtask

  task automatic check_tx_sequence(input string tag);
    int mism = 0;
    check({tag, "_len"}, 32'(tx_seen.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_seen.size() && i < tx_exp.size(); i++)
      if (tx_seen[i] !== tx_exp[i]) mism++;
    check({tag, "_order"}, 32'(mism), 32'd0);
    check({tag, "_retrigger"}, 32'(bad_pulses), 32'd0);
  endtask

  task automatic rx_send(input logic [7:0] b);
    int k = 0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else                     m_ovr = 1'b1;
    nsends++;
    have_data_rx = 1'b1;
    data_rx      = b;
    do begin tick; k++; end while (data_rx_ack !== 1'b1 && k < 10);
    check("rx_ack_seen", 32'(data_rx_ack), 32'd1);
    tick;
    have_data_rx = 1'b0;
    tick;
  endtask

  task automatic rx_read_check(input string tag);
    logic [7:0] d, e;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    rd(2'd0, d);
    check(tag, 32'(d), 32'(e));
  endtask

  initial begin
    logic [7:0] d, e, b;
    int n, p0;

    rst = 1'b1;
    bus.bus_addr = 2'd0; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0; bus.bus_re = 1'b0;
    have_data_rx = 1'b0; data_rx = 8'h00;
    repeat (3) tick;
    check("rst_have_data_tx", 32'(have_data_tx), 32'd0);
    check("rst_data_tx",      32'(data_tx),      32'd0);
    check("rst_ack",          32'(data_rx_ack),  32'd0);
    check("rst_rdata",        32'(bus.bus_rdata), 32'd0);
    rst = 1'b0;
    tick;
    rd(2'd1, d); check("rst_status", 32'(d), 32'h04);
    rd(2'd3, d); check("rst_count",  32'(d), 32'h00);
    check("rst_irq", 32'(bus.irq), 32'd0);

    // Two bytes from idle: two pulses in order, no retrigger
    tx_write(8'h41);
    tx_write(8'h42);
    wait_tx_idle;
    check_tx_sequence("tx_two");
    check("tx_two_first", 32'(tx_seen[0]), 32'h41);
    rd(2'd1, d); check("tx_two_status", 32'(d), 32'(exp_status(1'b0)));

    // Five bytes while the core is busy: the fifth overflows
    p0 = tx_seen.size();
    tx_write(8'h10);
    wait_pulses(p0 + 1);
    for (int i = 0; i < 5; i++) tx_write(8'(8'h20 + i));
    rd(2'd3, d); check("ovf_count",  32'(d), 32'(exp_count()));
    check("ovf_count_hi", 32'(d[7:4]), 32'd4);
    rd(2'd1, d); check("ovf_status", 32'(d), 32'(exp_status(1'b1)));
    wr(2'd2, 8'h02); m_ovf = 1'b0;
    rd(2'd1, d); check("ovf_cleared", 32'(d), 32'(exp_status(1'b1)));
    wait_tx_idle;
    check_tx_sequence("tx_ovf");

    // Random bursts behind a busy core
    for (int r = 0; r < 4; r++) begin
      p0 = tx_seen.size();
      tx_write(8'($urandom));
      wait_pulses(p0 + 1);
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) tx_write(8'($urandom));
      rd(2'd3, d); check("rnd_tx_count",  32'(d), 32'(exp_count()));
      rd(2'd1, d); check("rnd_tx_status", 32'(d), 32'(exp_status(1'b1)));
      if (m_ovf) begin wr(2'd2, 8'h02); m_ovf = 1'b0; end
      wait_tx_idle;
      check_tx_sequence("rnd_tx");
    end

    // Single RX byte
    rx_send(8'h5A);
    check("rx_one_acks", 32'(acks), 32'(nsends));
    rd(2'd3, d); check("rx_one_count", 32'(d), 32'h01);
    check("rx_one_irq", 32'(bus.irq), 32'd1);
    rx_read_check("rx_one_data");
    rd(2'd1, d); check("rx_one_status", 32'(d), 32'h04);
    check("rx_one_irq_clr", 32'(bus.irq), 32'd0);

    // Fill RX then overrun
    for (int i = 0; i < 5; i++) rx_send(8'($urandom));
    rd(2'd1, d); check("rx_ovr_status", 32'(d), 32'(exp_status(1'b0)));
    check("rx_ovr_status_val", 32'(d), 32'h15);
    check("rx_ovr_irq", 32'(bus.irq), 32'(exp_irq()));
    wr(2'd2, 8'h01); m_ovr = 1'b0;

    // Capture into a full FIFO in the same cycle as a DATA read
    b = 8'($urandom);
    have_data_rx = 1'b1; data_rx = b;
    bus.bus_addr = 2'd0; bus.bus_re = 1'b1;
    tick;
    bus.bus_re = 1'b0;
    e = rx_q.pop_front();
    rx_q.push_back(b);
    nsends++;
    check("rx_same_cycle_data", 32'(bus.bus_rdata), 32'(e));
    check("rx_same_cycle_ack", 32'(data_rx_ack), 32'd1);
    tick; have_data_rx = 1'b0; tick;
    rd(2'd3, d); check("rx_same_cycle_count", 32'(d), 32'h04);
    rd(2'd1, d); check("rx_same_cycle_status", 32'(d), 32'(exp_status(1'b0)));
    for (int i = 0; i < 5; i++) rx_read_check("rx_drain");

    // Random RX traffic
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) rx_send(8'($urandom));
      else                           rx_read_check("rnd_rx_data");
    end
    rd(2'd3, d); check("rnd_rx_count",  32'(d), 32'(exp_count()));
    rd(2'd1, d); check("rnd_rx_status", 32'(d), 32'(exp_status(1'b0)));
    check("rnd_rx_irq", 32'(bus.irq), 32'(exp_irq()));
    check("rnd_rx_acks", 32'(acks), 32'(nsends));
    wr(2'd2, 8'h01); m_ovr = 1'b0;
    while (rx_q.size() != 0) rx_read_check("rnd_rx_drain");

    // Reset during WAIT_END with bytes still queued
    rx_send(8'h33);
    p0 = tx_seen.size();
    tx_write(8'hA1); tx_write(8'hA2); tx_write(8'hA3);
    wait_pulses(p0 + 1);
    rd(2'd1, d);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    check("mid_rst_have_data_tx", 32'(have_data_tx), 32'd0);
    check("mid_rst_data_tx",      32'(data_tx),      32'd0);
    check("mid_rst_ack",          32'(data_rx_ack),  32'd0);
    check("mid_rst_rdata",        32'(bus.bus_rdata), 32'd0);
    check("mid_rst_irq",          32'(bus.irq),      32'd0);
    rst = 1'b0;
    while (tx_exp.size() > tx_seen.size()) void'(tx_exp.pop_back());
    rx_q.delete();
    m_ovr = 1'b0; m_ovf = 1'b0;
    p0 = tx_seen.size();
    rd(2'd3, d); check("mid_rst_count", 32'(d), 32'h00);
    repeat (40) tick;
    check("mid_rst_no_pulse", 32'(tx_seen.size()), 32'(p0));
    rd(2'd1, d); check("mid_rst_status", 32'(d), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_host_if.md
Name: uart_host_if

Overview:
- CPU-facing end of the UART core's byte handshake.
- Exposes a 4-register byte bus to the CPU and buffers traffic in TX and RX FIFOs.
- Feeds the core one byte at a time via have_data_tx/transmitting.
- Drains received bytes via have_data_rx/data_rx_ack.
- Sits between the CPU memory-mapped I/O decode and uart_core; both share one reset (core gets the inverted rst).

Parameters:
- FIFO_DEPTH, 4, entries per FIFO; legal values 2, 4, 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- bus_addr  in  2  register select.
- bus_wdata  in  8  write data.
- bus_we  in  1  single-cycle write strobe.
- bus_re  in  1  single-cycle read strobe.
- bus_rdata  out  8  registered read data.
- irq  out  1  rx_avail OR rx_overrun.
- data_tx  out  8  byte to core.
- have_data_tx  out  1  one-cycle start pulse to core.
- transmitting  in  1  core TX busy.
- data_rx  in  8  byte from core.
- have_data_rx  in  1  core byte valid (level).
- data_rx_ack  out  1  one-cycle ack to core.

Behaviour:
- Reset (rst=1 at posedge): bus_rdata=0x00, have_data_tx=0, data_tx=0x00, data_rx_ack=0, both FIFOs empty, sticky flags 0, both FSMs IDLE.
  - Reset mid-byte abandons the byte, and FIFO contents are lost.
- Register map, write side:
  - 0 DATA W: push bus_wdata into TX FIFO.
  - 2 CLEAR W: bit0=1 clears rx_overrun, bit1=1 clears tx_overflow.
  - 1 and 3: writes ignored.
- Register map, read side:
  - 0 DATA R: pop RX FIFO head.
  - 1 STATUS R: [0] rx_avail, [1] tx_full, [2] tx_empty, [3] tx_busy (TX FIFO non-empty or TX FSM not IDLE), [4] rx_overrun, [5] tx_overflow, [7:6]=0.
  - 2 reads 0x00.
  - 3 COUNT R: {tx_count[3:0], rx_count[3:0]}.
- Read latency: bus_rdata is valid the cycle after the bus_re edge and holds until the next read. Reading DATA with RX empty returns 0x00 with no pop.
- Writing DATA with TX full drops the byte and sets tx_overflow.
- bus_we and bus_re in the same cycle: both are honoured.
- FIFOs: circular, pointers wrap modulo FIFO_DEPTH; count width is 4 bits.
  - Simultaneous push+pop: both occur and count is unchanged.
  - Push while full with a simultaneous pop is accepted.
  - Sticky flag: set and clear in the same cycle -> set wins.
- TX FSM:
  - IDLE: if TX FIFO non-empty and transmitting=0, drive data_tx=head, have_data_tx=1 for exactly one cycle, pop, -> WAIT_START.
  - WAIT_START: wait transmitting=1 -> WAIT_END.
  - WAIT_END: wait transmitting=0 -> IDLE.
  - data_tx holds its value until the next launch.
  - Never asserts have_data_tx outside IDLE, so the core is never retriggered.
  - Back-to-back FIFO bytes go out with at most 2 idle cycles between core busy periods.
- RX FSM:
  - IDLE: if have_data_rx=1, push data_rx (if RX full: drop and set rx_overrun), drive data_rx_ack=1 for one cycle, -> ACK.
  - ACK: data_rx_ack=0; wait have_data_rx=0 -> IDLE.
  - This prevents double capture of one byte.
  - The CPU popping in the same cycle as a capture into a full FIFO counts as push+pop, so no overrun.
- irq is combinational from flags, so no extra latency.

Test Plan:
- Reset, then read STATUS -> 0x04 (tx_empty only); read COUNT -> 0x00; irq=0.
- Write 0x41, 0x42 to DATA with a core model (transmitting high 20 cycles after pulse) -> exactly two have_data_tx pulses with data_tx 0x41 then 0x42; second pulse only after transmitting falls; STATUS ends at 0x04.
- Write 5 bytes back-to-back with FIFO_DEPTH=4 while core busy -> 5th dropped, STATUS[5]=1, COUNT high nibble=4; CLEAR write 0x02 -> bit5 cleared.
- Core presents have_data_rx=1 with data_rx=0x5A, dropping only 1 cycle after ack -> one push, one ack pulse, COUNT=0x01, irq=1; DATA read returns 0x5A next cycle, then rx_avail=0 and irq=0.
- Fill RX with 4 bytes, present a 5th -> dropped, STATUS[4]=1; fill to full and present a byte in the same cycle as a DATA read -> no overrun, count stays 4.
- Assert rst during WAIT_END with 2 bytes queued -> next cycle all outputs at reset values, COUNT=0x00, no further have_data_tx pulses.
